// File: rtl/dct8_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dct8_mac_sequencer
// Purpose  : 1-D 8-point DCT-II; 64 products serialised through a shared
//            multiplier over a start/done handshake, results on valid/ready.
// Revision : 1.0
// ============================================================================
module dct8_mac_sequencer #(
    parameter int DATA_W = 16,
    parameter int PROD_W = 32,
    parameter int ACC_W  = 35,
    parameter int FRAC   = 15,
    parameter int OUT_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] mul_in1,
    output logic [DATA_W-1:0] mul_in2,
    output logic              mul_start,
    input  logic [PROD_W-1:0] mul_out,
    input  logic              mul_done,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    output logic [2:0]        out_idx,
    input  logic              out_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    // Q1.15 DCT-II basis, row-major C[k][n]
    localparam logic signed [15:0] c_coef_rom [64] = '{
        16'sd11585,  16'sd11585,  16'sd11585,  16'sd11585,  16'sd11585,  16'sd11585,  16'sd11585,  16'sd11585,
        16'sd16069,  16'sd13623,  16'sd9102,   16'sd3196,  -16'sd3196,  -16'sd9102,  -16'sd13623, -16'sd16069,
        16'sd15137,  16'sd6270,  -16'sd6270,  -16'sd15137, -16'sd15137, -16'sd6270,   16'sd6270,   16'sd15137,
        16'sd13623, -16'sd3196,  -16'sd16069, -16'sd9102,   16'sd9102,   16'sd16069,  16'sd3196,  -16'sd13623,
        16'sd11585, -16'sd11585, -16'sd11585,  16'sd11585,  16'sd11585, -16'sd11585, -16'sd11585,  16'sd11585,
        16'sd9102,  -16'sd16069,  16'sd3196,   16'sd13623, -16'sd13623, -16'sd3196,   16'sd16069, -16'sd9102,
        16'sd6270,  -16'sd15137,  16'sd15137, -16'sd6270,  -16'sd6270,   16'sd15137, -16'sd15137,  16'sd6270,
        16'sd3196,  -16'sd9102,   16'sd13623, -16'sd16069,  16'sd16069, -16'sd13623,  16'sd9102,  -16'sd3196
    };
    localparam int c_rnd = 1 << (FRAC - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [DATA_W-1:0]        r_x [8];
    logic [2:0]               r_wcnt;
    logic [2:0]               r_k;
    logic [2:0]               r_n;
    logic signed [ACC_W-1:0]  r_acc;
    logic [OUT_W-1:0]         r_out_data;
    logic signed [ACC_W-1:0]  w_acc_sum;
    logic signed [ACC_W-1:0]  w_acc_rnd;

    assign w_acc_sum = r_acc + {{(ACC_W-PROD_W){mul_out[PROD_W-1]}}, mul_out};
    assign w_acc_rnd = w_acc_sum + ACC_W'(c_rnd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        mul_start   = 1'b0;
        mul_in1     = '0;
        mul_in2     = '0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        out_idx     = r_k;
        out_data    = r_out_data;
        case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && r_wcnt == 3'd7) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                mul_start   = 1'b1;
                mul_in1     = r_x[r_n];
                mul_in2     = c_coef_rom[{r_k, r_n}];
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                mul_in1 = r_x[r_n];
                mul_in2 = c_coef_rom[{r_k, r_n}];
                if (mul_done) w_state_nxt = (r_n == 3'd7) ? S_OUT : S_ISSUE;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = (r_k == 3'd7) ? S_LOAD : S_ISSUE;
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // Sample store needs no reset: every block overwrites all eight entries
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && in_valid) begin
            r_x[r_wcnt] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt     <= 3'd0;
            r_k        <= 3'd0;
            r_n        <= 3'd0;
            r_acc      <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_k   <= 3'd0;
                    r_n   <= 3'd0;
                    r_acc <= '0;
                    if (in_valid) r_wcnt <= r_wcnt + 3'd1;
                end
                S_WAIT: begin
                    if (mul_done) begin
                        r_acc <= w_acc_sum;
                        r_n   <= r_n + 3'd1;
                        if (r_n == 3'd7) r_out_data <= w_acc_rnd[FRAC +: OUT_W];
                    end
                end
                S_OUT: begin
                    if (out_ready && r_k != 3'd7) begin
                        r_k   <= r_k + 3'd1;
                        r_acc <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dct8_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dct8_mac_sequencer
// Purpose  : Scoreboard bench with a behavioural variable-latency multiplier.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_dct8_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, mul_start, mul_done;
    logic        out_valid, out_ready, busy;
    logic [15:0] in_data, mul_in1, mul_in2;
    logic [31:0] mul_out;
    logic [19:0] out_data;
    logic [2:0]  out_idx;

    always #5 clk = ~clk;

    dct8_mac_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_start(mul_start), .mul_out(mul_out),
        .mul_done(mul_done), .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
        .out_ready(out_ready), .busy(busy)
    );

    typedef struct { int idx; int data; } exp_t;
    exp_t             sb[$];
    int               n_vec = 0;
    int               n_err = 0;
    int               coef [8][8];
    logic signed [15:0] stim [8];
    int               lat = 1;
    int               n_starts = 0, stab_err = 0, ovl_err = 0, stall_start = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural multiplier: done pulses lat cycles after the start cycle
    logic [15:0] cap_a, cap_b;
    logic        outst;
    int          cnt;
    always @(posedge clk) begin
        if (rst) begin
            mul_done <= 1'b0;
            outst    <= 1'b0;
            cnt      <= 0;
        end else begin
            mul_done <= 1'b0;
            if (outst && (mul_in1 !== cap_a || mul_in2 !== cap_b)) stab_err++;
            if (outst && mul_start) ovl_err++;
            if (out_valid && mul_start) stall_start++;
            if (mul_done) outst <= 1'b0;
            if (mul_start) begin
                n_starts++;
                cap_a <= mul_in1;
                cap_b <= mul_in2;
                outst <= 1'b1;
                cnt   <= lat - 1;
                if (lat == 1) begin
                    mul_done <= 1'b1;
                    mul_out  <= $signed(mul_in1) * $signed(mul_in2);
                end
            end else if (outst && cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    mul_done <= 1'b1;
                    mul_out  <= $signed(cap_a) * $signed(cap_b);
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid === 1'b1 && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_idx", int'(out_idx), e.idx);
                check("out_data", int'($signed(out_data)), e.data);
            end
        end
    end

    task automatic push_expected();
        exp_t   e;
        longint acc;
        for (int k = 0; k < 8; k++) begin
            acc = 0;
            for (int n = 0; n < 8; n++) acc += longint'(coef[k][n]) * longint'(stim[n]);
            e.idx  = k;
            e.data = int'((acc + 64'sd16384) >>> 15);
            sb.push_back(e);
        end
    endtask

    task automatic send_block();
        int t;
        n_starts = 0; stab_err = 0; ovl_err = 0; stall_start = 0;
        push_expected();
        for (int n = 0; n < 8; n++) begin
            t = 0;
            while (in_ready !== 1'b1 && t < 2000) begin @(posedge clk); #1; t++; end
            if (in_ready !== 1'b1) check("in_ready_timeout", 0, 1);
            in_valid = 1'b1;
            in_data  = stim[n];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = 16'h5a5a;
        check("busy_after_load", int'(busy), 1);
        check("in_ready_after_load", int'(in_ready), 0);
    endtask

    task automatic drain(input int stall_idx);
        int t;
        bit stalled;
        t = 0;
        stalled = 1'b0;
        while (sb.size() != 0 && t < 5000) begin
            if (stall_idx >= 0 && !stalled && out_valid === 1'b1 && int'(out_idx) == stall_idx) begin
                stalled   = 1'b1;
                out_ready = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk); #1;
                    if (i % 5 == 4) begin
                        check("stall_valid", int'(out_valid), 1);
                        check("stall_idx", int'(out_idx), stall_idx);
                        check("stall_data", int'($signed(out_data)), sb[0].data);
                    end
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            t++;
        end
        check("drain_left", sb.size(), 0);
        check("busy_end", int'(busy), 0);
        check("in_ready_end", int'(in_ready), 1);
        check("mul_starts", n_starts, 64);
        check("operand_stable", stab_err, 0);
        check("start_overlap", ovl_err, 0);
        check("start_in_out", stall_start, 0);
    endtask

    task automatic fill(input int v);
        for (int n = 0; n < 8; n++) stim[n] = 16'(v);
    endtask

    task automatic impulse();
        fill(0);
        stim[0] = 16'sd32767;
    endtask

    task automatic run(input int l, input int stall_idx);
        lat = l;
        send_block();
        drain(stall_idx);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        real c;
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++) begin
                c = (k == 0) ? 1.0 / (2.0 * $sqrt(2.0)) : 0.5;
                coef[k][n] = int'(32768.0 * c * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0));
            end
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_mul_start", int'(mul_start), 0);
        check("rst_mul_in1", int'(mul_in1), 0);
        check("rst_mul_in2", int'(mul_in2), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_idx", int'(out_idx), 0);
        rst = 1'b0;

        for (int pass = 0; pass < 2; pass++) begin
            fill(100);  run(pass == 0 ? 1 : 17, -1);
            impulse();  run(pass == 0 ? 1 : 17, -1);
            fill(-45);  run(pass == 0 ? 1 : 17, -1);
        end

        for (int n = 0; n < 8; n++) stim[n] = 16'($urandom_range(0, 65535));
        run(3, 3);

        // Abort a block while waiting on a product of row 2
        begin
            int t;
            impulse();
            lat = 17;
            send_block();
            t = 0;
            while (sb.size() > 6 && t < 5000) begin @(posedge clk); #1; t++; end
            while (mul_start !== 1'b1 && t < 5000) begin @(posedge clk); #1; t++; end
            check("abort_reach_k2", int'(out_idx), 2);
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk); #1;
            check("abort_out_valid", int'(out_valid), 0);
            check("abort_mul_start", int'(mul_start), 0);
            check("abort_in_ready", int'(in_ready), 1);
            check("abort_busy", int'(busy), 0);
            sb.delete();
            rst = 1'b0;
        end
        impulse();
        run(2, -1);

        for (int n = 0; n < 8; n++) stim[n] = 16'($urandom_range(0, 65535));
        run(5, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dct8_mac_sequencer.md
Name: dct8_mac_sequencer

Overview:
- 1-D 8-point DCT-II stage.
- Accepts 8 signed 16-bit samples, then computes y[k] = sum over n of C[k][n]*x[n] for k = 0..7.
- Issues all 64 products serially through the shared Booth multiplier via its start/done handshake, and accumulates them.
- Emits the 8 coefficients in order k = 0..7 on a valid/ready output; two instances plus a transpose buffer form the 2-D DCT.

Parameters:
- DATA_W, 16: sample and coefficient width; also the multiplier operand width.
- PROD_W, 32: multiplier product width.
- ACC_W, 35: accumulator width (PROD_W+3).
- FRAC, 15: coefficient fraction bits (Q1.15).
- OUT_W, 20: output width; covers the worst-case magnitude (below 2^19) with no saturation.
- Only the default values are verified.

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  sample present
- in_data  in  16  signed sample x[n], arriving in order n = 0..7
- in_ready  out  1  block is accepting samples
- mul_in1  out  16  multiplier operand: sample
- mul_in2  out  16  multiplier operand: coefficient
- mul_start  out  1  one-cycle multiply request
- mul_out  in  32  signed product
- mul_done  in  1  product valid
- out_valid  out  1  coefficient present
- out_data  out  20  signed y[k]
- out_idx  out  3  k of the current out_data
- out_ready  in  1  downstream accepts
- busy  out  1  high from the 8th accepted sample until the last output handshake

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state LOAD, in_ready=1, mul_start=0, mul_in1=0, mul_in2=0, out_valid=0, out_data=0, out_idx=0, busy=0; sample counter, k, n and accumulator cleared. Reset overrides everything, including mid-operation; no outputs are emitted for an aborted block.
- Internal ROM holds C[k][n] = round(32768*c(k)*cos((2n+1)k*pi/16)), with c(0) = 1/(2*sqrt2) and c(k>0) = 1/2.
  - Magnitudes: 11585 (k=0 and cos pi/4 terms), 16069, 15137, 13623, 9102, 6270, 3196.
  - Signs per DCT-II.
- LOAD:
  - in_ready=1; each cycle with in_valid=1 stores in_data at the write counter, then increments it.
  - The 8th accepted sample moves the block to ISSUE with k=0, n=0, acc=0, busy=1.
  - in_valid is ignored outside LOAD.
- ISSUE (1 cycle):
  - mul_in1=x[n], mul_in2=C[k][n], mul_start=1; next state WAIT.
- WAIT:
  - mul_start=0; mul_in1 and mul_in2 held stable.
  - mul_done in the cycle immediately after ISSUE is honoured.
  - On mul_done: acc += sign-extended mul_out.
  - If n=7, go to OUT; otherwise n+1 and go to ISSUE.
  - Wait is unbounded; no timeout.
- OUT:
  - out_valid=1, out_idx=k, out_data = (acc + 2^14) >>> 15. This is round-half-up via arithmetic shift; take the low 20 bits.
  - out_data and out_idx are registered and stable while out_valid=1 and out_ready=0. No mul_start is issued while stalled.
  - On out_ready: if k=7, go to LOAD with busy=0 and in_ready=1 the next cycle. Otherwise k+1, n=0, acc=0, go to ISSUE.
- Exactly 64 mul_start pulses per block, one per product, never overlapping an outstanding multiply.
- Latency, 8th sample to first out_valid: 8*(1+Lm)+1 cycles, where Lm = cycles from mul_start to mul_done.

Test Plan:
- x[n]=100 for all n, out_ready=1 -> out_idx 0..7 in order; out_data = 283, then 0 for k=1..7; busy drops after idx 7.
- x0=32767, x1..x7=0 -> out_data = 11585, 16069, 15137, 13623, 11585, 9102, 6270, 3196.
- x[n]=-45 for all n -> y0=-127, y1..y7=0; checks sign-extension and rounding of negatives.
- Behavioural multiplier with mul_done latency 1, then 17 cycles -> identical results to the above; exactly 64 mul_start pulses; operands constant between each start and its done.
- out_ready held low 20 cycles while out_idx=3 -> out_valid, out_data, out_idx unchanged; no mul_start during stall; remaining outputs correct after release.
- rst asserted during WAIT at k=2 -> next cycle out_valid=0, mul_start=0, in_ready=1, busy=0; the following impulse block is produced correctly.
